// File: rtl/serial_rx_pkg.sv
// Shared definitions for the serial frame receiver: state encoding, default sync
// nibble and bit-counter sizing.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2
  } rx_state_e;

  localparam logic [3:0]  SyncDefault = 4'b1011;
  localparam int unsigned MaxDataW    = 16;
  // Wide enough to hold any legal payload bit index.
  localparam int unsigned CntW        = $clog2(MaxDataW + 1);

endpackage

// File: rtl/sync_hunter.sv
// Sliding 4-bit history over qualified serial bits. It flags the bit that
// completes the sync nibble.
module sync_hunter #(
  parameter logic [3:0] Sync = 4'b1011
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic match_o
);

  logic [3:0] hist_q, hist_d;
  logic [2:0] fill_q, fill_d;

  always_comb begin
    hist_d  = {hist_q[2:0], bit_i};
    fill_d  = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
    // The match includes the bit currently on bit_i.
    match_o = en_i && (fill_d == 3'd4) && (hist_d == Sync);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= 4'd0;
      fill_q <= 3'd0;
    end else if (clr_i) begin
      hist_q <= 4'd0;
      fill_q <= 3'd0;
    end else if (en_i) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: hunts for the sync nibble and assembles an MSB-first
// payload. It checks optional even parity and pulses VALID or PERR.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter logic [3:0]  SYNC      = SyncDefault,
  parameter int unsigned DATA_W    = 8,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              CP,
  input  logic              MR_n,
  input  logic              SI,
  input  logic              EN,
  output logic [DATA_W-1:0] DATA,
  output logic              VALID,
  output logic              PERR,
  output logic              LOCKED
);

  rx_state_e         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              locked_q;
  logic              match;

  sync_hunter #(
    .Sync (SYNC)
  ) u_sync_hunter (
    .clk_i   (CP),
    .rst_ni  (MR_n),
    .clr_i   (match),
    .en_i    (EN && (state_q == StHunt)),
    .bit_i   (SI),
    .match_o (match)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    par_d   = par_q;
    data_d  = data_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    unique case (state_q)
      StHunt: begin
        if (match) begin
          state_d = StData;
          cnt_d   = '0;
          par_d   = 1'b0;
        end
      end
      StData: begin
        if (EN) begin
          asm_d = {asm_q[DATA_W-2:0], SI};
          par_d = par_q ^ SI;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(DATA_W - 1)) begin
            if (PARITY_EN) begin
              state_d = StParity;
            end else begin
              state_d = StHunt;
              data_d  = asm_d;
              valid_d = 1'b1;
            end
          end
        end
      end
      StParity: begin
        if (EN) begin
          state_d = StHunt;
          if ((par_q ^ SI) == 1'b0) begin
            data_d  = asm_q;
            valid_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge CP or negedge MR_n) begin
    if (!MR_n) begin
      state_q  <= StHunt;
      cnt_q    <= '0;
      asm_q    <= '0;
      par_q    <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      par_q    <= par_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      locked_q <= (state_d != StHunt);
    end
  end

  assign DATA   = data_q;
  assign VALID  = valid_q;
  assign PERR   = perr_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: a frame-level model checked every cycle on a parity
// and a no-parity instance, plus directed literal checks.
module tb_serial_frame_rx;

  localparam int SYNC_V = 11;
  localparam int DW     = 8;

  typedef struct {
    int hist;
    int hlen;
    bit locked;
    int word;
    int got;
    int data;
    bit valid;
    bit perr;
  } model_t;

  logic       clk = 1'b0;
  logic       rst_p = 1'b0, si_p = 1'b0, en_p = 1'b0;
  logic       rst_n = 1'b0, si_n = 1'b0, en_n = 1'b0;
  logic [7:0] data_p, data_n;
  logic       valid_p, perr_p, locked_p;
  logic       valid_n, perr_n, locked_n;

  int nerr = 0;
  int nchk = 0;
  int cyc = 0;
  int vcnt_p = 0, pcnt_p = 0, vcnt_n = 0, pcnt_n = 0;
  int vcyc_n[2];
  int vdat_n[2];
  int base_v, base_p;

  model_t mp, mn;

  always #5 clk = ~clk;

  serial_frame_rx #(.SYNC(4'b1011), .DATA_W(8), .PARITY_EN(1'b1)) dut_p (
    .CP(clk), .MR_n(rst_p), .SI(si_p), .EN(en_p),
    .DATA(data_p), .VALID(valid_p), .PERR(perr_p), .LOCKED(locked_p)
  );

  serial_frame_rx #(.SYNC(4'b1011), .DATA_W(8), .PARITY_EN(1'b0)) dut_n (
    .CP(clk), .MR_n(rst_n), .SI(si_n), .EN(en_n),
    .DATA(data_n), .VALID(valid_n), .PERR(perr_n), .LOCKED(locked_n)
  );

  function automatic model_t model_reset();
    model_t m;
    m.hist = 0; m.hlen = 0; m.locked = 0; m.word = 0; m.got = 0;
    m.data = 0; m.valid = 0; m.perr = 0;
    return m;
  endfunction

  function automatic model_t model_idle(model_t m);
    model_t n = m;
    n.valid = 0;
    n.perr  = 0;
    return n;
  endfunction

  // One qualified bit, described at frame level: window search, then payload, then parity.
  function automatic model_t model_next(model_t m, bit b, bit par_en);
    model_t n = m;
    n.valid = 0;
    n.perr  = 0;
    if (!m.locked) begin
      n.hist = (m.hist * 2 + int'(b)) % 16;
      n.hlen = (m.hlen < 4) ? m.hlen + 1 : 4;
      if (n.hlen == 4 && n.hist == SYNC_V) begin
        n.locked = 1; n.word = 0; n.got = 0; n.hist = 0; n.hlen = 0;
      end
    end else if (m.got < DW) begin
      n.word = m.word * 2 + int'(b);
      n.got  = m.got + 1;
      if (n.got == DW && !par_en) begin
        n.valid = 1; n.data = n.word; n.locked = 0;
      end
    end else begin
      if ((($countones(m.word) + int'(b)) % 2) == 0) begin
        n.valid = 1; n.data = m.word;
      end else begin
        n.perr = 1;
      end
      n.locked = 0;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_p) begin
    if (!rst_p)    mp <= model_reset();
    else if (en_p) mp <= model_next(mp, si_p, 1'b1);
    else           mp <= model_idle(mp);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mn <= model_reset();
    else if (en_n) mn <= model_next(mn, si_n, 1'b0);
    else           mn <= model_idle(mn);
  end

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always begin
    @(negedge clk);
    cyc++;
    check("valid_p", int'(valid_p), int'(mp.valid));
    check("perr_p", int'(perr_p), int'(mp.perr));
    check("locked_p", int'(locked_p), int'(mp.locked));
    check("data_p", int'(data_p), mp.data);
    check("valid_n", int'(valid_n), int'(mn.valid));
    check("perr_n", int'(perr_n), int'(mn.perr));
    check("locked_n", int'(locked_n), int'(mn.locked));
    check("data_n", int'(data_n), mn.data);
    if (valid_p) vcnt_p++;
    if (perr_p) pcnt_p++;
    if (perr_n) pcnt_n++;
    if (valid_n) begin
      if (vcnt_n < 2) begin
        vcyc_n[vcnt_n] = cyc;
        vdat_n[vcnt_n] = int'(data_n);
      end
      vcnt_n++;
    end
  end

  task automatic send_p(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      si_p = v[i];
      en_p = 1'b1;
    end
  endtask

  task automatic send_n(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      si_n = v[i];
      en_n = 1'b1;
    end
  endtask

  task automatic idle_p(input int n);
    repeat (n) begin
      @(negedge clk);
      en_p = 1'b0;
    end
    #1;
  endtask

  task automatic reset_p();
    @(negedge clk);
    #2 rst_p = 1'b0;
    en_p = 1'b0;
    si_p = 1'b0;
    @(negedge clk);
    #2 rst_p = 1'b1;
  endtask

  initial begin
    // Reset and idle
    reset_p();
    idle_p(10);
    check("idle_data", int'(data_p), 0);
    check("idle_locked", int'(locked_p), 0);
    check("idle_valid", int'(valid_p), 0);

    // Good frame 1011 A5 p=0
    base_v = vcnt_p;
    send_p(32'hB, 4);
    send_p(32'hA5, 8);
    send_p(32'h0, 1);
    idle_p(1);
    check("good_valid_now", int'(valid_p), 1);
    check("good_data", int'(data_p), 'hA5);
    check("good_model_pin", mp.data, 'hA5);
    check("good_locked_low", int'(locked_p), 0);
    idle_p(1);
    check("good_valid_gone", int'(valid_p), 0);
    check("good_vcnt", vcnt_p - base_v, 1);

    // Parity error after reset
    reset_p();
    base_v = vcnt_p;
    base_p = pcnt_p;
    send_p(32'hB, 4);
    send_p(32'hA5, 8);
    send_p(32'h1, 1);
    idle_p(1);
    check("perr_now", int'(perr_p), 1);
    check("perr_no_valid", int'(valid_p), 0);
    idle_p(1);
    check("perr_gone", int'(perr_p), 0);
    check("perr_data_kept", int'(data_p), 0);
    check("perr_hunt", int'(locked_p), 0);
    check("perr_counts", (vcnt_p - base_v) * 16 + (pcnt_p - base_p), 1);

    // Overlapped sync (1 1011) with gaps in the payload 0x3C
    base_v = vcnt_p;
    send_p(32'hD, 4);
    idle_p(1);
    check("ovl_not_yet", int'(locked_p), 0);
    send_p(32'h1, 1);
    idle_p(1);
    check("ovl_locked_5th", int'(locked_p), 1);
    send_p(32'h1, 3);
    idle_p(3);
    send_p(32'h1C, 5);
    send_p(32'h0, 1);
    idle_p(1);
    check("ovl_valid", int'(valid_p), 1);
    check("ovl_data", int'(data_p), 'h3C);
    idle_p(1);
    check("ovl_vcnt", vcnt_p - base_v, 1);

    // Back-to-back, no parity: 1011 81 1011 7E
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_n({8'h0, 4'hB, 8'h81, 4'hB, 8'h7E}, 24);
    @(negedge clk);
    en_n = 1'b0;
    @(negedge clk);
    #1;
    check("b2b_vcnt", vcnt_n, 2);
    check("b2b_spacing", vcyc_n[1] - vcyc_n[0], 12);
    check("b2b_data0", vdat_n[0], 'h81);
    check("b2b_data1", vdat_n[1], 'h7E);
    check("b2b_perr", pcnt_n, 0);

    // Reset mid-frame, then a good 0x55 frame
    base_v = vcnt_p;
    base_p = pcnt_p;
    send_p(32'hB, 4);
    send_p(32'h2, 3);
    reset_p();
    idle_p(2);
    check("abort_locked", int'(locked_p), 0);
    check("abort_quiet", (vcnt_p - base_v) + (pcnt_p - base_p), 0);
    send_p(32'hB, 4);
    send_p(32'h55, 8);
    send_p(32'h0, 1);
    idle_p(1);
    check("after_abort_valid", int'(valid_p), 1);
    check("after_abort_data", int'(data_p), 'h55);
    idle_p(2);
    check("after_abort_vcnt", vcnt_p - base_v, 1);
    check("after_abort_perr", pcnt_p - base_p, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
# serial_frame_rx

Downstream consumer of the 4-bit universal shift register stage. It samples the serial stream leaving that register's last stage (Q[3]), hunts for a fixed sync nibble, and assembles the following payload into a parallel word. It then checks an optional even-parity bit and presents the word with a one-cycle valid pulse. It is the receive half of the team's serial-link lab chain.

## Interface
- SYNC, 4'b1011: sync nibble; the first bit received is compared against SYNC[3].
- DATA_W, 8: payload width in bits (legal range 2–16).
- PARITY_EN, 1: 1 means one even-parity bit follows the payload; 0 means no parity bit.
- CP  input  1: clock; all state updates on rising edge.
- MR_n  input  1: asynchronous, active-low reset.
- SI  input  1: serial data bit; connects to Q[3] of the upstream shift register.
- EN  input  1: bit qualifier; SI is sampled only on edges where EN=1.
- DATA  output  DATA_W: last accepted payload, MSB-first assembled; holds between frames.
- VALID  output  1: one-cycle pulse; DATA was just updated with a good frame.
- PERR  output  1: one-cycle pulse; parity mismatch, frame discarded.
- LOCKED  output  1: high while in DATA or PARITY state.

## Operation
- States: HUNT, DATA, PARITY.
- HUNT:
  - Each qualified bit shifts into a 4-bit history as {hist[2:0], SI}; a 3-bit fill count saturates at 4.
  - When fill is 4 (including the current bit) and the updated history equals SYNC, go to DATA with bit count 0.
  - A partial overlap continues the search. Example: 1 1011 matches on the fifth bit.
- DATA:
  - Each qualified bit shifts into the assembly register MSB-first and increments the bit count.
  - After DATA_W bits, go to PARITY if PARITY_EN=1; otherwise complete the frame.
- PARITY:
  - One qualified bit p.
  - If the XOR of all payload bits and p is 0: complete the frame.
  - Otherwise: PERR<=1, DATA unchanged, go to HUNT.
- Completing a frame: DATA<=assembly, VALID<=1, go to HUNT, history and fill cleared.
  - Payload bits never count toward the next sync match.
- EN=0: no state, counter, history or assembly change. VALID and PERR still self-clear.
- Reset values: DATA=0, VALID=0, PERR=0, LOCKED=0, state=HUNT, history=0, fill=0, count=0.
- Reset mid-frame aborts the frame immediately. No VALID or PERR is produced for it.

## Timing
- Sample point: the rising CP edge with EN=1.
- Output latency: VALID/PERR are registered and high for exactly the cycle after the edge that sampled the final bit (last payload bit, or the parity bit).
- LOCKED is registered. It rises in the cycle after the sync-completing edge and falls in the cycle after the final-bit edge, coincident with VALID/PERR.
- Back-to-back frames: the edge that ends VALID may already sample the first sync bit of the next frame. Minimum frame spacing is therefore 0 idle bits.
- Throughput: one bit per cycle at EN=1 continuously. Frame length is 4+DATA_W+PARITY_EN bits.
- VALID and PERR are never high in the same cycle.

## Structure
- Shared package serial_rx_pkg holds:
  - the state encoding (HUNT=2'd0, DATA=2'd1, PARITY=2'd2);
  - the default SYNC constant;
  - the max-DATA_W constant used to size the bit counter.
- One sub-module is natural: sync_hunter. It contains the 4-bit history, the fill counter and the match output, with clear and enable inputs driven by the top FSM.
- The top module holds the FSM, the bit counter, the assembly register, the parity accumulator and the output registers.

## Test plan
- Reset/idle: MR_n low, then high with EN=0 for 10 cycles. DATA=0x00, VALID=0, PERR=0 and LOCKED=0 throughout.
- Good frame (defaults): send 1011, 10100101, p=0 with EN=1 continuously. VALID is high exactly one cycle after the parity edge, DATA=0xA5, PERR=0.
- Parity error: send 1011, 0xA5, p=1. PERR pulses one cycle, VALID stays 0, DATA keeps its previous value (0x00 after reset), state returns to HUNT.
- Overlapped sync and gaps:
  - Send 1 1011, then 0x3C (00111100) with EN deasserted for 3 cycles mid-payload, then p=0.
  - Required: the match occurs on the fifth bit, the gaps are ignored, DATA=0x3C.
- Back-to-back and no-parity: with PARITY_EN=0, send two frames with zero gap, 1011+0x81 then 1011+0x7E. VALID pulses twice, 12 cycles apart, with DATA=0x81 then 0x7E.
- Reset mid-frame: pull MR_n low after 3 payload bits, release, then send a full good frame 1011+0x55+p=0. No output for the aborted frame, then VALID with DATA=0x55.
